// File: rtl/daq_strobe_gen.sv
// Per-channel power-of-two sample-strobe generator with glitch-free rate changes and phase-align sync.
// Define DAQ_STROBE_COUNT_EN to build the per-channel sample counters and sticky overflow flags.

module daq_strobe_lane #(
  parameter int SEL_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 clr,
  output logic                 strobe,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);
  localparam int DW = (1 << SEL_WIDTH) - 1;
  localparam logic [DW:0] ONE = 1;

  logic [DW-1:0]        div_cnt;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [DW:0]          span;
  logic [DW:0]          last;
  logic                 term;
  logic                 strobe_set;

  assign span       = ONE << sel_q;
  assign last       = span - ONE;
  assign term       = (div_cnt == last[DW-1:0]);
  assign strobe_set = !sync && en && term;

  // sel_q only reloads at a period boundary (or while idle/synced), so a
  // rate change never shortens or stretches the period in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sel_q   <= '0;
      strobe  <= 1'b0;
    end else if (sync || !en) begin
      div_cnt <= '0;
      sel_q   <= sel;
      strobe  <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      sel_q   <= sel;
      strobe  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
      strobe  <= 1'b0;
    end
  end

`ifdef DAQ_STROBE_COUNT_EN
  // Clear wins over the old count but not over a strobe landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= strobe_set ? CNT_WIDTH'(1) : '0;
      ovf <= 1'b0;
    end else if (strobe_set) begin
      cnt <= cnt + CNT_WIDTH'(1);
      if (&cnt) ovf <= 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign cnt        = '0;
  assign ovf        = 1'b0;
`endif

endmodule

module daq_strobe_gen #(
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              wb_clk,
  input  logic                              wb_rst_n,
  input  logic [NUM_CHANNELS*SEL_WIDTH-1:0] speed_select,
  input  logic [NUM_CHANNELS-1:0]           channel_enable,
  input  logic                              sync_i,
  input  logic [NUM_CHANNELS-1:0]           count_clear_i,
  output logic [NUM_CHANNELS-1:0]           strobe_o,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] sample_count_o,
  output logic [NUM_CHANNELS-1:0]           overflow_o
);
  logic [NUM_CHANNELS-1:0][SEL_WIDTH-1:0] sel_arr;
  logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] cnt_arr;

  assign sel_arr        = speed_select;
  assign sample_count_o = cnt_arr;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    daq_strobe_lane #(
      .SEL_WIDTH(SEL_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_lane (
      .clk   (wb_clk),
      .rst_n (wb_rst_n),
      .sel   (sel_arr[g]),
      .en    (channel_enable[g]),
      .sync  (sync_i),
      .clr   (count_clear_i[g]),
      .strobe(strobe_o[g]),
      .cnt   (cnt_arr[g]),
      .ovf   (overflow_o[g])
    );
  end

endmodule
